// File: rtl/reset_seq_pkg.sv
// Shared types for the reset sequencer: the controller state encoding.
package reset_seq_pkg;

   typedef enum logic [1:0] {
      HOLD,
      RELEASE,
      RUN,
      DONE
   } rs_state_e;

endpackage

// File: rtl/reset_sequencer.sv
// Holds all domain resets after power-on, releases them one by one with a fixed gap,
// and replays the same hold/release walk on a software-selected subset of domains.
module reset_sequencer
   import reset_seq_pkg::*;
#(
   parameter int NUM_DOMAINS = 4,
   parameter int HOLD_CYCLES = 16,
   parameter int GAP_CYCLES  = 4
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   sw_rst_req,
   input  logic [NUM_DOMAINS-1:0] dom_mask,
   output logic                   sw_rst_ack,
   output logic [NUM_DOMAINS-1:0] dom_reset,
   output logic                   all_ready,
   output logic                   busy
);

   localparam int MAX_CNT = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
   localparam int CNT_W   = $clog2(MAX_CNT + 1);
   localparam int IDX_W   = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;

   localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_CYCLES);
   localparam logic [CNT_W-1:0] HOLD_EMPTY = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_CYCLES - 1);

   rs_state_e              state, stateNext;
   logic [NUM_DOMAINS-1:0] tgt, tgtNext;
   logic [IDX_W-1:0]       idx, idxNext;
   logic [CNT_W-1:0]       cnt, cntNext;
   logic                   softRun, softRunNext;
   logic [NUM_DOMAINS-1:0] domNext;
   logic                   readyNext, ackNext, busyNext;

   logic                   firstFound, laterFound;
   logic [IDX_W-1:0]       firstPos, laterPos;

   // Priority encoders over the target mask: the lowest set bit overall, and the
   // lowest set bit strictly above the domain currently being released.
   always_comb begin
      firstFound = 1'b0;
      firstPos   = '0;
      laterFound = 1'b0;
      laterPos   = '0;
      for (int i = NUM_DOMAINS - 1; i >= 0; i--) begin
         if (tgt[i]) begin
            firstFound = 1'b1;
            firstPos   = IDX_W'(i);
         end
         if (tgt[i] && (i > int'(idx))) begin
            laterFound = 1'b1;
            laterPos   = IDX_W'(i);
         end
      end
   end

   // State and datapath registers; outputs are registered so nothing downstream
   // sees a combinational path from the request inputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= HOLD;
         tgt        <= '1;
         idx        <= '0;
         cnt        <= '0;
         softRun    <= 1'b0;
         dom_reset  <= '1;
         all_ready  <= 1'b0;
         sw_rst_ack <= 1'b0;
         busy       <= 1'b1;
      end else begin
         state      <= stateNext;
         tgt        <= tgtNext;
         idx        <= idxNext;
         cnt        <= cntNext;
         softRun    <= softRunNext;
         dom_reset  <= domNext;
         all_ready  <= readyNext;
         sw_rst_ack <= ackNext;
         busy       <= busyNext;
      end
   end

   // Sequencing: hold every targeted reset, then walk the set bits upward. An empty
   // soft-reset mask skips the walk and completes one cycle before a release would.
   always_comb begin
      stateNext   = state;
      tgtNext     = tgt;
      idxNext     = idx;
      cntNext     = cnt;
      softRunNext = softRun;
      domNext     = dom_reset;
      case (state)
         HOLD: begin
            domNext = dom_reset | tgt;
            cntNext = cnt + CNT_W'(1);
            if (!firstFound) begin
               if (cnt == HOLD_EMPTY) begin
                  stateNext = DONE;
                  cntNext   = '0;
               end
            end else if (cnt == HOLD_LAST) begin
               stateNext         = RELEASE;
               idxNext           = firstPos;
               cntNext           = '0;
               domNext[firstPos] = 1'b0;
            end
         end
         RELEASE: begin
            cntNext = cnt + CNT_W'(1);
            if (cnt == GAP_LAST) begin
               cntNext = '0;
               if (laterFound) begin
                  idxNext           = laterPos;
                  domNext[laterPos] = 1'b0;
               end else begin
                  stateNext = softRun ? DONE : RUN;
               end
            end
         end
         RUN: begin
            if (sw_rst_req) begin
               tgtNext     = dom_mask;
               cntNext     = '0;
               softRunNext = 1'b1;
               stateNext   = HOLD;
            end
         end
         DONE: begin
            if (!sw_rst_req) begin
               softRunNext = 1'b0;
               stateNext   = RUN;
            end
         end
         default: stateNext = HOLD;
      endcase
   end

   // Status flags follow the state being entered, so they line up with that state.
   always_comb begin
      readyNext = (stateNext == RUN);
      ackNext   = (stateNext == DONE);
      busyNext  = (stateNext == HOLD) || (stateNext == RELEASE);
   end

endmodule
